// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: merges ALU and load results into an in-order
// FIFO and drains at most one register write per cycle. Also exports a mask of
// destinations whose writes are still queued or being presented.
module rf_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     pend_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] count_t;

  localparam count_t DepthC   = count_t'(DEPTH);
  localparam count_t DepthM1C = count_t'(DEPTH - 1);

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  ptr_t            wptr_q, rptr_q;
  count_t          count_q;
  logic            rf_we_q;
  logic [4:0]      rf_a3_q;
  logic [XLEN-1:0] rf_wd_q;

  logic   alu_store, mem_store, deq;
  ptr_t   mem_wptr;
  count_t count_d;
  ptr_t   offs;

  // Handshakes look only at the registered count; the ALU owns the last free slot.
  always_comb begin
    alu_ready = !flush && (count_q < DepthC);
    mem_ready = !flush && ((count_q < DepthM1C) || ((count_q < DepthC) && !alu_valid));
    // x0 results complete the handshake but are never stored.
    alu_store = alu_valid && alu_ready && (alu_rd != 5'd0);
    mem_store = mem_valid && mem_ready && (mem_rd != 5'd0);
    deq       = (count_q != '0) && !flush;
    mem_wptr  = alu_store ? (wptr_q + ptr_t'(1)) : wptr_q;
    count_d   = count_q + count_t'(alu_store) + count_t'(mem_store) - count_t'(deq);
  end

  // FIFO storage; ALU entry lands first so it is older than a same-cycle load.
  always_ff @(posedge clk) begin
    if (alu_store) begin
      rd_mem[wptr_q]   <= alu_rd;
      data_mem[wptr_q] <= alu_data;
    end
    if (mem_store) begin
      rd_mem[mem_wptr]   <= mem_rd;
      data_mem[mem_wptr] <= mem_data;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rf_we_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_q + ptr_t'(alu_store) + ptr_t'(mem_store);
      count_q <= count_d;
      rf_we_q <= deq;
      if (deq) begin
        rptr_q  <= rptr_q + ptr_t'(1);
        rf_a3_q <= rd_mem[rptr_q];
        rf_wd_q <= data_mem[rptr_q];
      end
    end
  end

  // Pending mask: every live FIFO entry plus the write currently on the port.
  always_comb begin
    pend_mask = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = ptr_t'(i) - rptr_q;
      if (count_t'(offs) < count_q) pend_mask[rd_mem[i]] = 1'b1;
    end
    if (rf_we_q) pend_mask[rf_a3_q] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign rf_we = rf_we_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;

endmodule
